// File: rtl/acorn_init_engine_pkg.sv
// Shared ACORN-128 constants, FSM state type and bit-level helper functions
// used by the init engine and its single-step datapath.
package acorn_pkg;

  localparam int unsigned ACORN_STATE_W    = 293;
  localparam int unsigned ACORN_INIT_STEPS = 1792;
  localparam int unsigned ACORN_KEY_W      = 128;
  localparam int unsigned ACORN_IV_W       = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acorn_fsm_e;

  function automatic logic acorn_maj(input logic x, input logic y, input logic z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic acorn_ch(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Bits [6:0] of the step index give i, i-128 and i mod 128 in every range.
  function automatic logic acorn_mbit(input int unsigned i,
                                      input logic [ACORN_KEY_W-1:0] key,
                                      input logic [ACORN_IV_W-1:0]  iv);
    logic [6:0] b;
    b = i[6:0];
    if (i < 128)       return key[b];
    else if (i < 256)  return iv[b];
    else if (i == 256) return ~key[0];
    else               return key[b];
  endfunction

endpackage

// File: rtl/acorn_init_engine_if.sv
// Start/done handshake and key/IV/state bus between the front end and the
// ACORN-128 init engine.
interface acorn_init_engine_if #(
  parameter int unsigned KEY_W   = 128,
  parameter int unsigned IV_W    = 128,
  parameter int unsigned STATE_W = 293
);
  logic               start;
  logic [KEY_W-1:0]   key_in;
  logic [IV_W-1:0]    iv_in;
  logic               abort;
  logic               ready;
  logic               busy;
  logic               done;
  logic               state_vld;
  logic [STATE_W-1:0] state_out;

  modport master (
    output start, key_in, iv_in, abort,
    input  ready, busy, done, state_vld, state_out
  );

  modport slave (
    input  start, key_in, iv_in, abort,
    output ready, busy, done, state_vld, state_out
  );
endinterface

// File: rtl/acorn_init_engine_step.sv
// One ACORN-128 state update (state_update128): LFSR feedback, keystream bit,
// nonlinear feedback with message bit, then shift by one.
module acorn_step
  import acorn_pkg::*;
(
  input  logic [ACORN_STATE_W-1:0] s_i,
  input  logic                     mbit_i,
  input  logic                     ca_i,
  input  logic                     cb_i,
  output logic [ACORN_STATE_W-1:0] s_o
);
  logic [ACORN_STATE_W-1:0] u;
  logic                     ks;
  logic                     f;

  // Each LFSR tap reads pre-update values, matching the top-down in-place order.
  always_comb begin
    u      = s_i;
    u[289] = s_i[289] ^ s_i[235] ^ s_i[230];
    u[230] = s_i[230] ^ s_i[196] ^ s_i[193];
    u[193] = s_i[193] ^ s_i[160] ^ s_i[154];
    u[154] = s_i[154] ^ s_i[111] ^ s_i[107];
    u[107] = s_i[107] ^ s_i[66]  ^ s_i[61];
    u[61]  = s_i[61]  ^ s_i[23]  ^ s_i[0];
    ks = u[12] ^ u[154] ^ acorn_maj(u[235], u[61], u[193])
       ^ acorn_ch(u[230], u[111], u[66]);
    f  = u[0] ^ ~u[107] ^ acorn_maj(u[244], u[23], u[160])
       ^ (ca_i & u[196]) ^ (cb_i & ks) ^ mbit_i;
    s_o = {f, u[ACORN_STATE_W-1:1]};
  end
endmodule

// File: rtl/acorn_init_engine.sv
// ACORN-128 initialization engine: loads key/IV and runs the 1792 init steps,
// P chained steps per clock, handing the state over with a done pulse.
module acorn_init_engine
  import acorn_pkg::*;
#(
  parameter int unsigned P          = 1,
  parameter int unsigned KEY_W      = ACORN_KEY_W,
  parameter int unsigned IV_W       = ACORN_IV_W,
  parameter int unsigned STATE_W    = ACORN_STATE_W,
  parameter int unsigned INIT_STEPS = ACORN_INIT_STEPS
) (
  input  logic           clk,
  input  logic           rst_n,
  acorn_init_engine_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(INIT_STEPS + 1);

  if (KEY_W != ACORN_KEY_W) begin : g_bad_key
    $error("acorn_init_engine: KEY_W must be 128");
  end
  if (IV_W != ACORN_IV_W) begin : g_bad_iv
    $error("acorn_init_engine: IV_W must be 128");
  end
  if (STATE_W != ACORN_STATE_W) begin : g_bad_state
    $error("acorn_init_engine: STATE_W must be 293");
  end
  if (P < 1 || P > 32 || (INIT_STEPS % P) != 0) begin : g_bad_p
    $error("acorn_init_engine: P must be 1..32 and divide INIT_STEPS");
  end

  acorn_fsm_e         st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [IV_W-1:0]    iv_q, iv_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic               vld_q, vld_d;

  logic [STATE_W-1:0] chain [0:P];
  logic [P-1:0]       mbit;

  assign chain[0] = state_q;

  for (genvar j = 0; j < P; j++) begin : g_step
    assign mbit[j] = acorn_mbit(32'(cnt_q) + 32'(j), key_q, iv_q);
    acorn_step u_step (
      .s_i    (chain[j]),
      .mbit_i (mbit[j]),
      .ca_i   (1'b1),
      .cb_i   (1'b1),
      .s_o    (chain[j+1])
    );
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    iv_d    = iv_q;
    state_d = state_q;
    vld_d   = vld_q;
    unique case (st_q)
      IDLE: begin
        if (bus.start) begin
          st_d    = RUN;
          key_d   = bus.key_in;
          iv_d    = bus.iv_in;
          state_d = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          st_d    = IDLE;
          state_d = '0;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end else begin
          state_d = chain[P];
          cnt_d   = cnt_q + CNT_W'(P);
          if (cnt_q + CNT_W'(P) == CNT_W'(INIT_STEPS)) begin
            st_d  = DONE;
            vld_d = 1'b1;
          end
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      key_q   <= '0;
      iv_q    <= '0;
      state_q <= '0;
      vld_q   <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      iv_q    <= iv_d;
      state_q <= state_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.ready     = (st_q == IDLE);
  assign bus.busy      = (st_q == RUN);
  assign bus.done      = (st_q == DONE);
  assign bus.state_vld = vld_q;
  assign bus.state_out = state_q;
endmodule
